// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a single-port registered block RAM.
// Round-robin or fixed priority, with a bounded per-master lock.
module mem_arbiter #(
  parameter bit RR       = 1'b1,
  parameter int LOCK_MAX = 16
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic        M0_REQ,
  input  logic        M0_WR,
  input  logic [31:0] M0_A,
  input  logic [31:0] M0_DI,
  input  logic        M0_LOCK,
  output logic        M0_ACK,
  output logic        M0_RVALID,
  output logic [31:0] M0_DO,
  input  logic        M1_REQ,
  input  logic        M1_WR,
  input  logic [31:0] M1_A,
  input  logic [31:0] M1_DI,
  input  logic        M1_LOCK,
  output logic        M1_ACK,
  output logic        M1_RVALID,
  output logic [31:0] M1_DO,
  output logic        RAM_CS,
  output logic        RAM_WR,
  output logic [31:0] RAM_A,
  output logic [31:0] RAM_DI,
  input  logic [31:0] RAM_DO
);

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } lock_e;

  localparam logic [7:0] LMAX = 8'(LOCK_MAX);

  lock_e      st_q, st_d;
  logic       last_q, last_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] owe_q, owe_d;
  logic       rv0_q, rv0_d;
  logic       rv1_q, rv1_d;
  logic       gnt0, gnt1;
  logic [7:0] cnt_inc;

  // owe_q marks a master that must win the next contended cycle
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (RESETN) begin
      unique case (st_q)
        LOCK0: gnt0 = M0_REQ;
        LOCK1: gnt1 = M1_REQ;
        default: begin
          if (M0_REQ && M1_REQ) begin
            if (owe_q[1]) begin
              gnt1 = 1'b1;
            end else if (owe_q[0]) begin
              gnt0 = 1'b1;
            end else if (RR) begin
              gnt0 = last_q;
              gnt1 = !last_q;
            end else begin
              gnt0 = 1'b1;
            end
          end else begin
            gnt0 = M0_REQ;
            gnt1 = M1_REQ;
          end
        end
      endcase
    end
  end

  always_comb begin
    st_d    = st_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    owe_d   = owe_q;
    cnt_inc = cnt_q + 8'd1;
    rv0_d   = gnt0 && !M0_WR;
    rv1_d   = gnt1 && !M1_WR;
    if (gnt0) last_d = 1'b0;
    if (gnt1) last_d = 1'b1;
    if ((gnt0 && owe_q[0]) || (gnt1 && owe_q[1]))
      owe_d = 2'b00;
    unique case (st_q)
      LOCK0: begin
        cnt_d = cnt_inc;
        if (cnt_inc == LMAX) begin
          st_d   = FREE;
          last_d = 1'b0;
          owe_d  = 2'b10;
        end else if (!M0_LOCK) begin
          st_d = FREE;
        end
      end
      LOCK1: begin
        cnt_d = cnt_inc;
        if (cnt_inc == LMAX) begin
          st_d   = FREE;
          last_d = 1'b1;
          owe_d  = 2'b01;
        end else if (!M1_LOCK) begin
          st_d = FREE;
        end
      end
      default: begin
        if (gnt0 && M0_LOCK) begin
          st_d  = LOCK0;
          cnt_d = 8'd0;
          owe_d = 2'b00;
        end else if (gnt1 && M1_LOCK) begin
          st_d  = LOCK1;
          cnt_d = 8'd0;
          owe_d = 2'b00;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      st_q   <= FREE;
      last_q <= 1'b1;
      cnt_q  <= 8'd0;
      owe_q  <= 2'b00;
      rv0_q  <= 1'b0;
      rv1_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      last_q <= last_d;
      cnt_q  <= cnt_d;
      owe_q  <= owe_d;
      rv0_q  <= rv0_d;
      rv1_q  <= rv1_d;
    end
  end

  always_comb begin
    RAM_CS = gnt0 || gnt1;
    RAM_WR = 1'b0;
    RAM_A  = 32'd0;
    RAM_DI = 32'd0;
    if (gnt0) begin
      RAM_WR = M0_WR;
      RAM_A  = M0_A;
      RAM_DI = M0_DI;
    end else if (gnt1) begin
      RAM_WR = M1_WR;
      RAM_A  = M1_A;
      RAM_DI = M1_DI;
    end
  end

  // reset low masks a pending read response in the same cycle
  assign M0_ACK    = gnt0;
  assign M1_ACK    = gnt1;
  assign M0_RVALID = rv0_q && RESETN;
  assign M1_RVALID = rv1_q && RESETN;
  assign M0_DO     = RAM_DO;
  assign M1_DO     = RAM_DO;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin and a fixed-priority instance,
// each with its own RAM, checked against a transaction-level model.
module tb_mem_arbiter;

  localparam int LM = 4;

  logic        CLK = 1'b0;
  logic        rstn;
  logic [1:0]  req [2];
  logic [1:0]  wr  [2];
  logic [1:0]  lk  [2];
  logic [31:0] ad  [2][2];
  logic [31:0] di  [2][2];
  logic [1:0]  ack [2];
  logic [1:0]  rv  [2];
  logic [31:0] dout[2][2];
  logic        cs  [2];
  logic        rw  [2];
  logic [31:0] ra  [2];
  logic [31:0] rdi [2];
  logic [31:0] rdo [2];
  logic [31:0] mem [2][64];

  int          own [2];
  int          held[2];
  int          last[2];
  int          owe [2];
  int          pend[2];
  int          gcur[2];
  logic [31:0] pdat[2];
  logic [31:0] mm  [2][64];
  int          nv;
  int          ne;

  always #5 CLK = ~CLK;

  mem_arbiter #(.RR(1'b1), .LOCK_MAX(LM)) u_rr (
    .CLK(CLK), .RESETN(rstn),
    .M0_REQ(req[0][0]), .M0_WR(wr[0][0]), .M0_A(ad[0][0]),
    .M0_DI(di[0][0]), .M0_LOCK(lk[0][0]), .M0_ACK(ack[0][0]),
    .M0_RVALID(rv[0][0]), .M0_DO(dout[0][0]),
    .M1_REQ(req[0][1]), .M1_WR(wr[0][1]), .M1_A(ad[0][1]),
    .M1_DI(di[0][1]), .M1_LOCK(lk[0][1]), .M1_ACK(ack[0][1]),
    .M1_RVALID(rv[0][1]), .M1_DO(dout[0][1]),
    .RAM_CS(cs[0]), .RAM_WR(rw[0]), .RAM_A(ra[0]),
    .RAM_DI(rdi[0]), .RAM_DO(rdo[0])
  );

  mem_arbiter #(.RR(1'b0), .LOCK_MAX(LM)) u_fx (
    .CLK(CLK), .RESETN(rstn),
    .M0_REQ(req[1][0]), .M0_WR(wr[1][0]), .M0_A(ad[1][0]),
    .M0_DI(di[1][0]), .M0_LOCK(lk[1][0]), .M0_ACK(ack[1][0]),
    .M0_RVALID(rv[1][0]), .M0_DO(dout[1][0]),
    .M1_REQ(req[1][1]), .M1_WR(wr[1][1]), .M1_A(ad[1][1]),
    .M1_DI(di[1][1]), .M1_LOCK(lk[1][1]), .M1_ACK(ack[1][1]),
    .M1_RVALID(rv[1][1]), .M1_DO(dout[1][1]),
    .RAM_CS(cs[1]), .RAM_WR(rw[1]), .RAM_A(ra[1]),
    .RAM_DI(rdi[1]), .RAM_DO(rdo[1])
  );

  always @(posedge CLK) begin
    for (int k = 0; k < 2; k++) begin
      if (cs[k]) begin
        if (rw[k]) mem[k][ra[k][5:0]] <= rdi[k];
        else rdo[k] <= mem[k][ra[k][5:0]];
      end
    end
  end

  // which master the rules say wins this cycle (-1 = none)
  function automatic int pick(int k);
    if (!rstn) return -1;
    if (own[k] >= 0) return req[k][own[k]] ? own[k] : -1;
    if (req[k] == 2'b11) begin
      if (owe[k] >= 0) return owe[k];
      if (k == 0) return 1 - last[k];
      return 0;
    end
    if (req[k][0]) return 0;
    if (req[k][1]) return 1;
    return -1;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nv++;
    assert (obs === exp) else begin
      ne++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic update(int k, int g);
    int o;
    if (!rstn) begin
      own[k] = -1; held[k] = 0; last[k] = 1;
      owe[k] = -1; pend[k] = -1;
      return;
    end
    pend[k] = (g >= 0 && !wr[k][g]) ? g : -1;
    if (g >= 0) begin
      if (wr[k][g]) mm[k][ad[k][g][5:0]] = di[k][g];
      else pdat[k] = mm[k][ad[k][g][5:0]];
      last[k] = g;
      if (owe[k] == g) owe[k] = -1;
    end
    if (own[k] < 0) begin
      if (g >= 0 && lk[k][g]) begin
        own[k] = g; held[k] = 0; owe[k] = -1;
      end
    end else begin
      o = own[k];
      held[k]++;
      if (held[k] == LM) begin
        last[k] = o; owe[k] = 1 - o; own[k] = -1;
      end else if ((g == o && !lk[k][o]) || (!req[k][o] && !lk[k][o])) begin
        own[k] = -1;
      end
    end
  endtask

  task automatic cycle(int n = 1);
    int g;
    logic [31:0] ea;
    for (int c = 0; c < n; c++) begin
      @(negedge CLK);
      for (int k = 0; k < 2; k++) begin
        g = pick(k);
        gcur[k] = g;
        ea = (g < 0) ? 32'd0 : ((g == 0) ? 32'd1 : 32'd2);
        chk($sformatf("ack%0d", k), {30'd0, ack[k]}, ea);
        chk($sformatf("cs%0d", k), {31'd0, cs[k]}, {31'd0, g >= 0});
        chk($sformatf("ramwr%0d", k), {31'd0, rw[k]},
            (g >= 0) ? {31'd0, wr[k][g]} : 32'd0);
        chk($sformatf("rama%0d", k), ra[k], (g >= 0) ? ad[k][g] : 32'd0);
        chk($sformatf("ramdi%0d", k), rdi[k],
            (g >= 0 && wr[k][g]) ? di[k][g] : ((g >= 0) ? di[k][g] : 32'd0));
        ea = (rstn && pend[k] >= 0) ? (32'd1 << pend[k]) : 32'd0;
        chk($sformatf("rvalid%0d", k), {30'd0, rv[k]}, ea);
        if (rstn && pend[k] >= 0)
          chk($sformatf("do%0d", k), dout[k][pend[k]], pdat[k]);
      end
      @(posedge CLK);
      for (int k = 0; k < 2; k++) update(k, gcur[k]);
      #1;
    end
  endtask

  task automatic setall(int m, logic r, logic w, logic [31:0] a,
                        logic [31:0] d, logic l);
    for (int k = 0; k < 2; k++) begin
      req[k][m] = r; wr[k][m] = w; ad[k][m] = a;
      di[k][m] = d;  lk[k][m] = l;
    end
  endtask

  initial begin
    nv = 0; ne = 0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 64; i++) begin
        mem[k][i] = 32'hA500_0000 + i;
        mm[k][i]  = 32'hA500_0000 + i;
      end
      own[k] = -1; held[k] = 0; last[k] = 1;
      owe[k] = -1; pend[k] = -1; pdat[k] = 32'd0;
      rdo[k] = 32'd0;
    end
    rstn = 1'b0;
    setall(0, 0, 0, 0, 0, 0);
    setall(1, 0, 0, 0, 0, 0);
    cycle(2);
    rstn = 1'b1;
    setall(0, 1, 0, 32'h10, 0, 0);
    cycle();
    setall(0, 0, 0, 0, 0, 0);
    cycle();
    setall(0, 1, 0, 32'h3, 0, 0);
    setall(1, 1, 0, 32'h4, 0, 0);
    cycle(6);
    setall(0, 0, 0, 0, 0, 0);
    setall(1, 1, 1, 32'h5, 32'hDEAD_BEEF, 1);
    cycle();
    setall(0, 1, 0, 32'h5, 0, 0);
    cycle(2);
    setall(1, 1, 1, 32'h5, 32'hDEAD_BEEF, 0);
    cycle();
    setall(1, 0, 0, 0, 0, 0);
    cycle(2);
    setall(0, 1, 0, 32'h7, 0, 1);
    setall(1, 1, 0, 32'h8, 0, 0);
    cycle(8);
    setall(0, 0, 0, 0, 0, 0);
    setall(1, 0, 0, 0, 0, 0);
    cycle(2);
    setall(0, 1, 0, 32'h9, 0, 0);
    cycle();
    setall(0, 0, 0, 0, 0, 0);
    rstn = 1'b0;
    cycle();
    rstn = 1'b1;
    setall(0, 1, 0, 32'h1, 0, 0);
    setall(1, 1, 0, 32'h2, 0, 0);
    cycle(3);
    for (int t = 0; t < 3000; t++) begin
      rstn = ($urandom_range(0, 199) != 0);
      for (int k = 0; k < 2; k++) begin
        for (int m = 0; m < 2; m++) begin
          if (gcur[k] == m || !req[k][m]) begin
            req[k][m] = ($urandom_range(0, 3) != 0);
            wr[k][m]  = $urandom_range(0, 1) == 1;
            ad[k][m]  = 32'($urandom_range(0, 7));
            di[k][m]  = $urandom;
            lk[k][m]  = ($urandom_range(0, 2) == 0);
          end
        end
      end
      cycle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", nv, ne);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter RR, default 1, arbitration mode: 1 = round-robin, 0 = fixed priority with M0 highest.
REQ-002 Parameter LOCK_MAX, default 16, maximum consecutive cycles one master may hold a lock (range 1..255).
REQ-003 CLK  in  1  single clock; all state updates on the rising edge.
REQ-004 RESETN  in  1  reset, synchronous and active-low.
REQ-005 Mn_REQ  in  1  access request from master n (n = 0, 1); held high until Mn_ACK.
REQ-006 Mn_WR  in  1  write qualifier for master n; 1 = write, 0 = read.
REQ-007 Mn_A  in  32  word address from master n.
REQ-008 Mn_DI  in  32  write data from master n.
REQ-009 Mn_LOCK  in  1  master n requests exclusive ownership across accesses.
REQ-010 Mn_ACK  out  1  access of master n issued to RAM this cycle.
REQ-011 Mn_RVALID  out  1  read data for master n valid on Mn_DO this cycle.
REQ-012 Mn_DO  out  32  read data to master n.
REQ-013 RAM_CS  out  1  RAM enable.
REQ-014 RAM_WR  out  1  RAM write enable.
REQ-015 RAM_A  out  32  RAM address.
REQ-016 RAM_DI  out  32  RAM write data.
REQ-017 RAM_DO  in  32  RAM read data; valid one cycle after a read enable (registered block RAM).

Function
REQ-018 The block SHALL issue at most one RAM access per cycle, chosen combinationally from the current Mn_REQ values and the registered state.
REQ-019 The block SHALL drive RAM_CS=1 and Mn_ACK=1 for the granted master in the same cycle, with RAM_WR/RAM_A/RAM_DI muxed from that master.
REQ-020 The block SHALL drive RAM_CS=0, RAM_WR=0, RAM_A=0 and RAM_DI=0 in any cycle with no grant.
REQ-021 The block SHALL never assert RAM_WR without RAM_CS, and never assert both M0_ACK and M1_ACK.
REQ-022 The block SHALL assert Mn_RVALID exactly one cycle after an acked read of master n, and never after a write.
REQ-023 The block SHALL drive both Mn_DO with RAM_DO; consumers SHALL qualify Mn_DO with Mn_RVALID.
REQ-024 The block SHALL hold a registered pointer LAST (last granted master); it updates on every grant.
REQ-025 In round-robin mode with both requesting and no lock, the block SHALL grant the master not equal to LAST.
REQ-026 In fixed mode with both requesting and no lock, the block SHALL grant M0.
REQ-027 A single requester SHALL be granted in the same cycle regardless of mode (zero-wait when uncontended).
REQ-028 The lock FSM SHALL have states FREE, LOCK0 and LOCK1.
REQ-029 FREE -> LOCKn when master n is acked with Mn_LOCK=1.
REQ-030 In LOCKn only master n SHALL be granted; the other master's request waits without ACK.
REQ-031 LOCKn -> FREE when master n is acked with Mn_LOCK=0, or in any cycle with Mn_REQ=0 and Mn_LOCK=0.
REQ-032 An 8-bit lock counter SHALL clear on entry to LOCKn and increment each cycle in LOCKn.
REQ-033 When the counter reaches LOCK_MAX, the FSM SHALL force LOCKn -> FREE, with LAST=n, so that a waiting other master wins the next contended cycle.
REQ-034 A forced release SHALL not re-enter LOCKn on the same master until the other master has been granted once, if the other master is requesting.
REQ-035 A release edge and a new request SHALL resolve in the same cycle: arbitration in the cycle after the transition uses FREE rules.

Reset
REQ-036 With RESETN=0 at a rising edge, the block SHALL set the FSM to FREE, LAST=1, the lock counter to 0, and both Mn_RVALID to 0.
REQ-037 During reset, all Mn_ACK and RAM_CS SHALL be 0, and a read acked in the cycle before reset SHALL produce no RVALID.

Verification
REQ-038 Scenario: M0 read A=0x10 alone -> M0_ACK and RAM_CS in cycle t; M0_RVALID=1 in t+1 with M0_DO=RAM content at 0x10.
REQ-039 Scenario: RR=1, both request reads continuously from reset -> grants alternate M0, M1, M0, M1; each RVALID follows its own ACK by one cycle.
REQ-040 Scenario: RR=0, both request continuously -> M0 acked every cycle and M1 never acked until M0_REQ drops.
REQ-041 Scenario: M1 write 0xDEADBEEF to 0x05 with M1_LOCK=1 for 3 accesses while M0 requests -> M0 waits, then is acked in the cycle after M1 drops LOCK; a subsequent read of 0x05 returns 0xDEADBEEF.
REQ-042 Scenario: LOCK_MAX=4, M0 holds LOCK and REQ indefinitely while M1 requests -> forced release after 4 cycles, and M1 is acked in the next cycle.
REQ-043 Scenario: RESETN=0 asserted in the cycle after a read ACK -> no RVALID, FSM FREE, and the first contended grant after reset goes to M0.
